hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage core. Sits beside the decode/execute pipeline registers and sequences them: it forwards operands into Execute, inserts load-use bubbles, flushes on taken branches, freezes the whole pipeline while data memory is not ready, and raises a sticky fault on a memory wait that runs too long. An optional bank of saturating performance counters records stall, flush and wait activity.

## Interface
Parameters:
- WAIT_LIMIT, 255: consecutive memory-wait cycles before fault; legal range 1..65535.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- RS1_D, RS2_D  in  5  source registers of the instruction in Decode.
- RS1_E, RS2_E, RD_E  in  5  source and destination registers in Execute.
- RegWriteE, ResultSrcE  in  1  Execute writes the register file; Execute is a load (ResultSrcE=1).
- PCSrcE  in  1  branch resolved taken in Execute.
- RD_M, RD_W  in  5  destination registers in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  write enables in Memory and Writeback.
- mem_ready  in  1  data memory completes its access this cycle.
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 10 Memory-stage ALU result, 01 ResultW.
- StallF, StallD, StallE, StallM, StallW  out  1  hold the corresponding pipeline register.
- FlushD, FlushE  out  1  clear the Decode/Execute pipeline register to a bubble.
- mem_timeout  out  1  sticky fault: memory wait reached WAIT_LIMIT.
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W  performance counters.

## Operation
- Forwarding, per operand A (RS1_E) and B (RS2_E):
  - 10 if RegWriteM, RD_M≠0 and RD_M matches the source register.
  - Otherwise 01 if RegWriteW, RD_W≠0 and RD_W matches.
  - Otherwise 00.
  - Memory beats Writeback. Register 0 is never forwarded.
- Load-use: lwstall = ResultSrcE & RegWriteE & RD_E≠0 & (RD_E==RS1_D | RD_E==RS2_D). It asserts StallF, StallD and FlushE.
- Taken branch: PCSrcE asserts FlushD and FlushE. StallF and StallD stay 0, because the branch cancels any load-use bubble in the same cycle.
- Memory wait: !mem_ready asserts all five Stall* signals and forces FlushD=FlushE=0. This has the highest priority: it suppresses the branch and load-use actions, which reapply on the first ready cycle.
- Priority order: reset > FAULT > memory wait > taken branch > load-use.
- FSM states:
  - RUN: idle. Moves to WAIT when mem_ready=0; wait_timer is loaded with 1.
  - WAIT: wait_timer increments each cycle that mem_ready=0. Returns to RUN on mem_ready=1; the timer clears. Moves to FAULT when the timer equals WAIT_LIMIT while mem_ready=0.
  - FAULT: all Stall*=1, all Flush*=0, mem_timeout=1. Left only by rst.
  - Worked example: with WAIT_LIMIT=1, the first not-ready cycle moves the FSM to FAULT at the next edge.
- wait_timer width is clog2(WAIT_LIMIT+1).

## Timing
- Forward*, Stall* and Flush* are combinational from the inputs and the current state, valid in the same cycle.
- The FSM, wait_timer, mem_timeout and the counters update on the rising edge of clk.
- While rst=1:
  - Forward*=00, all Stall*=0 and all Flush*=0 (combinationally gated).
  - At the edge: state=RUN, wait_timer=0, mem_timeout=0, all counters=0.
- Reset asserted mid-WAIT or in FAULT returns the block to RUN at the next edge, with no residual stall.
- mem_timeout rises on the cycle after the edge that enters FAULT. It stays 1 until that rst edge.

## Configuration
- PERF_COUNTERS_EN defined:
  - stall_cnt increments on each cycle with an effective load-use bubble (lwstall & !PCSrcE & mem_ready, in RUN or WAIT).
  - flush_cnt increments on each effective taken-branch flush.
  - wait_cnt increments on each cycle with mem_ready=0 outside FAULT.
  - All three saturate at 2^CNT_W−1.
- PERF_COUNTERS_EN undefined: no counter flops are instantiated and stall_cnt, flush_cnt and wait_cnt are tied to 0.

## Test plan
- Back-to-back ALU dependency: RegWriteM=1, RD_M=3, RS1_E=3; simultaneously RegWriteW=1, RD_W=3 -> ForwardAE=10. Same case with RD_M=0 and RD_W=3 -> ForwardAE=01. RS2_E=0 with RD_W=0 -> ForwardBE=00.
- Load-use: ResultSrcE=1, RegWriteE=1, RD_E=5, RS2_D=5, mem_ready=1 -> StallF=StallD=FlushE=1 for one cycle; stall_cnt goes 0→1.
- Branch plus load-use in the same cycle: PCSrcE=1 with lwstall conditions true -> FlushD=FlushE=1, StallF=StallD=0; flush_cnt=1, stall_cnt=0.
- Memory wait of 3 cycles with WAIT_LIMIT=255 and PCSrcE=1 held -> all Stall*=1 and Flush*=0 for 3 cycles. On the ready cycle FlushD=FlushE=1. wait_cnt=3, FSM back in RUN, mem_timeout=0.
- Timeout: WAIT_LIMIT=4, mem_ready held 0 -> FAULT after 4 wait cycles. mem_timeout=1 and all stalls persist after mem_ready returns to 1. A 1-cycle rst clears mem_timeout and all stalls.
- Counter saturation and macro: CNT_W=4 with 20 wait cycles -> wait_cnt=15. Built without PERF_COUNTERS_EN -> all counters read 0 throughout.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use bubbles, branch flushes,
// memory-wait freeze with sticky timeout. Optional counters under PERF_COUNTERS_EN.
module hazard_ctrl #(
    parameter int unsigned WAIT_LIMIT = 255,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic             RegWriteE,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             mem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int unsigned TW = $clog2(WAIT_LIMIT + 1);
    localparam logic [TW:0] LIMIT = (TW+1)'(WAIT_LIMIT);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_FAULT} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] wait_timer, timer_nxt;
    logic [TW:0]   timer_inc;
    logic          lwstall;

    assign lwstall = ResultSrcE & RegWriteE & (RD_E != 5'd0) &
                     ((RD_E == RS1_D) | (RD_E == RS2_D));
    assign timer_inc = {1'b0, wait_timer} + (TW+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            wait_timer  <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_timer  <= timer_nxt;
            mem_timeout <= (state_nxt == S_FAULT);
        end
    end

    // The limit is compared against the count including the current not-ready
    // cycle, so WAIT_LIMIT=1 faults straight from RUN.
    always_comb begin
        state_nxt = state;
        timer_nxt = wait_timer;
        case (state)
            S_RUN: begin
                if (!mem_ready) begin
                    state_nxt = (LIMIT == (TW+1)'(1)) ? S_FAULT : S_WAIT;
                    timer_nxt = TW'(1);
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    state_nxt = S_RUN;
                    timer_nxt = '0;
                end else if (timer_inc == LIMIT) begin
                    state_nxt = S_FAULT;
                end else begin
                    timer_nxt = timer_inc[TW-1:0];
                end
            end
            default: state_nxt = S_FAULT;
        endcase
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (!rst) begin
            if (RegWriteM && RD_M != 5'd0 && RD_M == RS1_E)      ForwardAE = 2'b10;
            else if (RegWriteW && RD_W != 5'd0 && RD_W == RS1_E) ForwardAE = 2'b01;
            if (RegWriteM && RD_M != 5'd0 && RD_M == RS2_E)      ForwardBE = 2'b10;
            else if (RegWriteW && RD_W != 5'd0 && RD_W == RS2_E) ForwardBE = 2'b01;

            if (state == S_FAULT || !mem_ready) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                StallW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lwstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

`ifdef PERF_COUNTERS_EN
    logic active;
    assign active = (state != S_FAULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (active && mem_ready && !PCSrcE && lwstall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (active && mem_ready && PCSrcE && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (active && !mem_ready && wait_cnt != '1)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a negedge monitor checks.
module tb_hazard_ctrl;

    localparam int unsigned WL = 4;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
    logic          RegWriteE, ResultSrcE, PCSrcE, RegWriteM, RegWriteW, mem_ready;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

    hazard_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .mem_ready(mem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    typedef struct {
        logic [1:0]    fa, fb;
        logic [4:0]    st;
        logic [1:0]    fl;
        logic          to;
        logic [CW-1:0] sc, fc, wc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [CW-1:0] m_sc = '0, m_fc = '0, m_wc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ForwardAE", 32'(ForwardAE), 32'(e.fa));
            chk("ForwardBE", 32'(ForwardBE), 32'(e.fb));
            chk("Stall_FDEMW", 32'({StallF, StallD, StallE, StallM, StallW}), 32'(e.st));
            chk("Flush_DE", 32'({FlushD, FlushE}), 32'(e.fl));
            chk("mem_timeout", 32'(mem_timeout), 32'(e.to));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
            chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
            chk("wait_cnt", 32'(wait_cnt), 32'(e.wc));
        end
    end

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
        return (inc && v != '1) ? v + CW'(1) : v;
    endfunction

    task automatic defaults();
        rst = 1'b0;
        RS1_D = 5'd0; RS2_D = 5'd0; RS1_E = 5'd0; RS2_E = 5'd0; RD_E = 5'd0;
        RD_M = 5'd0; RD_W = 5'd0;
        RegWriteE = 1'b0; ResultSrcE = 1'b0; PCSrcE = 1'b0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; mem_ready = 1'b1;
    endtask

    // Inputs are already driven; push this cycle's expectation, then advance one clock.
    task automatic cyc(input logic [1:0] fa, input logic [1:0] fb, input logic [4:0] st,
                       input logic [1:0] fl, input logic to);
        exp_t e;
        logic si, fi, wi;
        e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.to = to;
`ifdef PERF_COUNTERS_EN
        e.sc = m_sc; e.fc = m_fc; e.wc = m_wc;
`else
        e.sc = '0; e.fc = '0; e.wc = '0;
`endif
        sb.push_back(e);
        si = !rst && st[4] && !st[1];
        fi = !rst && fl[1];
        wi = !rst && !mem_ready && !to;
        @(posedge clk);
        if (rst) begin
            m_sc = '0; m_fc = '0; m_wc = '0;
        end else begin
            m_sc = sat_inc(m_sc, si);
            m_fc = sat_inc(m_fc, fi);
            m_wc = sat_inc(m_wc, wi);
        end
        #1;
    endtask

    initial begin
        defaults();
        rst = 1'b1;
        @(posedge clk); #1;

        // reset gates every combinational output
        RegWriteM = 1'b1; RD_M = 5'd3; RS1_E = 5'd3; PCSrcE = 1'b1; mem_ready = 1'b0;
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);
        defaults();
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);

        // forwarding
        RegWriteM = 1'b1; RD_M = 5'd3; RegWriteW = 1'b1; RD_W = 5'd3; RS1_E = 5'd3;
        cyc(2'b10, 2'b00, 5'b00000, 2'b00, 1'b0);
        RD_M = 5'd0;
        cyc(2'b01, 2'b00, 5'b00000, 2'b00, 1'b0);
        RD_W = 5'd0;
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);
        defaults();
        RS1_E = 5'd7; RS2_E = 5'd7; RD_M = 5'd7; RD_W = 5'd7; RegWriteW = 1'b1;
        cyc(2'b01, 2'b01, 5'b00000, 2'b00, 1'b0);
        RS1_E = 5'd4; RS2_E = 5'd6; RD_M = 5'd6; RegWriteM = 1'b1; RD_W = 5'd4;
        cyc(2'b01, 2'b10, 5'b00000, 2'b00, 1'b0);

        // load-use and its non-triggering neighbours
        defaults();
        ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd5; RS2_D = 5'd5;
        cyc(2'b00, 2'b00, 5'b11000, 2'b01, 1'b0);
        defaults();
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);
        ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd0; RS1_D = 5'd0;
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);
        RegWriteE = 1'b0; RD_E = 5'd5; RS1_D = 5'd5;
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);

        // branch cancels a simultaneous load-use bubble
        defaults();
        ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd5; RS2_D = 5'd5; PCSrcE = 1'b1;
        cyc(2'b00, 2'b00, 5'b00000, 2'b11, 1'b0);
        defaults();
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);

        // 3-cycle memory wait with a taken branch held; branch applies on ready
        PCSrcE = 1'b1; mem_ready = 1'b0;
        repeat (3) cyc(2'b00, 2'b00, 5'b11111, 2'b00, 1'b0);
        mem_ready = 1'b1;
        cyc(2'b00, 2'b00, 5'b00000, 2'b11, 1'b0);
        defaults();
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);

        // timeout after WL not-ready cycles, sticky until reset
        mem_ready = 1'b0;
        repeat (WL) cyc(2'b00, 2'b00, 5'b11111, 2'b00, 1'b0);
        mem_ready = 1'b1; PCSrcE = 1'b1;
        cyc(2'b00, 2'b00, 5'b11111, 2'b00, 1'b1);
        mem_ready = 1'b0;
        cyc(2'b00, 2'b00, 5'b11111, 2'b00, 1'b1);
        rst = 1'b1;
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b1);
        defaults();
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);

        // reset in the middle of a wait leaves no residual stall
        mem_ready = 1'b0;
        repeat (2) cyc(2'b00, 2'b00, 5'b11111, 2'b00, 1'b0);
        rst = 1'b1;
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);
        defaults();
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);

        // 21 wait cycles in bursts below the limit saturate a 4-bit counter
        for (int b = 0; b < 7; b++) begin
            mem_ready = 1'b0;
            repeat (3) cyc(2'b00, 2'b00, 5'b11111, 2'b00, 1'b0);
            mem_ready = 1'b1;
            cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);
        end
        cyc(2'b00, 2'b00, 5'b00000, 2'b00, 1'b0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending expectations", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
